// File: rtl/neuron_pkg.sv
// neuron_pkg: shared types, default parameters and helpers for neuron_lif_n.
// Holds the FSM state enum, VW saturation, and the lane offset helper.
package neuron_pkg;

    localparam int DEF_N_IN       = 4;
    localparam int DEF_DW         = 8;
    localparam int DEF_VW         = 16;
    localparam int DEF_THRESHOLD  = 100;
    localparam int DEF_V_RESET    = 0;
    localparam int DEF_LEAK_SHIFT = 3;
    localparam int DEF_REFRAC_CYC = 2;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_UPDATE = 2'd2
`ifdef NEURON_REFRACTORY_EN
        ,
        S_REFRAC = 2'd3
`endif
    } state_t;

    // Bit offset of lane idx inside a packed vector of dw-bit lanes.
    function automatic int lane_lo(input int idx, input int dw);
        return idx * dw;
    endfunction

    // Clamp x to the signed range of a vw-bit value.
    function automatic logic signed [63:0] sat_vw(
        input logic signed [63:0] x,
        input int                 vw
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (vw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (vw - 1));
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

endpackage

// File: rtl/neuron_mac.sv
// neuron_mac: one signed multiply-accumulate lane with clear/load/enable.
// Ports: clk, i_clr, i_load/i_init, i_en, i_a, i_w, o_acc.
module neuron_mac
    import neuron_pkg::*;
#(
    parameter int DW = DEF_DW,
    parameter int AW = 35
) (
    input  logic                 clk,
    input  logic                 i_clr,
    input  logic                 i_load,
    input  logic                 i_en,
    input  logic signed [AW-1:0] i_init,
    input  logic signed [DW-1:0] i_a,
    input  logic signed [DW-1:0] i_w,
    output logic signed [AW-1:0] o_acc
);

    logic signed [2*DW-1:0] w_prod;
    logic signed [AW-1:0]   w_prod_x;
    logic signed [AW-1:0]   r_acc;

    assign w_prod   = i_a * i_w;
    assign w_prod_x = {{(AW - 2*DW){w_prod[2*DW-1]}}, w_prod};
    assign o_acc    = r_acc;

    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_acc <= '0;
        end else if (i_load) begin
            r_acc <= i_init;
        end else if (i_en) begin
            r_acc <= r_acc + w_prod_x;
        end
    end

endmodule

// File: rtl/neuron_lif_n.sv
// neuron_lif_n: N_IN-input leaky integrate-and-fire neuron, one MAC per cycle.
// Ports: clk, rst (sync, active-high), step_valid/step_ready handshake,
// a/w (packed signed lanes), bias, vp (membrane), spike and done pulses.
// Option macro NEURON_REFRACTORY_EN adds the refractory counter and state.
module neuron_lif_n
    import neuron_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int DW         = DEF_DW,
    parameter int VW         = DEF_VW,
    parameter int THRESHOLD  = DEF_THRESHOLD,
    parameter int V_RESET    = DEF_V_RESET,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int REFRAC_CYC = DEF_REFRAC_CYC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step_valid,
    output logic              step_ready,
    input  logic [N_IN*DW-1:0] a,
    input  logic [N_IN*DW-1:0] w,
    input  logic [DW-1:0]     bias,
    output logic [VW-1:0]     vp,
    output logic              spike,
    output logic              done
);

    localparam int AW = VW + 2*DW + $clog2(N_IN) + 1;
    localparam int IW = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IW-1:0]        LAST = IW'(N_IN - 1);
    localparam logic signed [VW-1:0] TH_V = VW'(THRESHOLD);
    localparam logic signed [VW-1:0] VR_V = VW'(V_RESET);

    state_t r_state;
    state_t w_next;

    logic [N_IN*DW-1:0]   r_a;
    logic [N_IN*DW-1:0]   r_w;
    logic signed [DW-1:0] r_bias;
    logic signed [VW-1:0] r_vp;
    logic signed [VW-1:0] r_leak;
    logic [IW-1:0]        r_idx;
    logic                 r_spike;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_en;
    logic                 w_upd;
    logic                 w_fire;
    logic signed [DW-1:0] w_a_lane;
    logic signed [DW-1:0] w_w_lane;
    logic signed [AW-1:0] w_init;
    logic signed [AW-1:0] w_acc;
    logic signed [AW:0]   w_sum;
    logic signed [63:0]   w_sat;
    logic signed [VW-1:0] w_vnew;

`ifdef NEURON_REFRACTORY_EN
    localparam int CW = (REFRAC_CYC > 0) ? $clog2(REFRAC_CYC + 1) : 1;
    logic [CW-1:0] r_cnt;
    logic          w_ref;
`else
    logic w_unused_refrac;
    assign w_unused_refrac = REFRAC_CYC[0];
`endif

    assign step_ready = (r_state == S_IDLE);
    assign vp         = r_vp;
    assign spike      = r_spike;
    assign done       = r_done;

    assign w_a_lane = r_a[lane_lo(int'(r_idx), DW) +: DW];
    assign w_w_lane = r_w[lane_lo(int'(r_idx), DW) +: DW];
    assign w_init   = {{(AW - VW){r_vp[VW-1]}}, r_vp};

    // acc + bias - leak, widened one bit so the sum itself never wraps.
    assign w_sum = {w_acc[AW-1], w_acc}
                 + {{(AW + 1 - DW){r_bias[DW-1]}}, r_bias}
                 - {{(AW + 1 - VW){r_leak[VW-1]}}, r_leak};
    assign w_sat  = sat_vw({{(63 - AW){w_sum[AW]}}, w_sum}, VW);
    assign w_vnew = w_sat[VW-1:0];
    assign w_fire = (w_vnew >= TH_V);

    neuron_mac #(
        .DW (DW),
        .AW (AW)
    ) u_mac (
        .clk    (clk),
        .i_clr  (rst),
        .i_load (w_accept),
        .i_en   (w_en),
        .i_init (w_init),
        .i_a    (w_a_lane),
        .i_w    (w_w_lane),
        .o_acc  (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_en     = 1'b0;
        w_upd    = 1'b0;
`ifdef NEURON_REFRACTORY_EN
        w_ref    = 1'b0;
`endif
        unique case (r_state)
            S_IDLE: begin
                if (step_valid) begin
                    w_accept = 1'b1;
                    w_next   = S_ACCUM;
`ifdef NEURON_REFRACTORY_EN
                    if (r_cnt != '0) w_next = S_REFRAC;
`endif
                end
            end
            S_ACCUM: begin
                w_en = 1'b1;
                if (r_idx == LAST) w_next = S_UPDATE;
            end
            S_UPDATE: begin
                w_upd  = 1'b1;
                w_next = S_IDLE;
            end
`ifdef NEURON_REFRACTORY_EN
            S_REFRAC: begin
                w_ref  = 1'b1;
                w_next = S_IDLE;
            end
`endif
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_w     <= '0;
            r_bias  <= '0;
            r_leak  <= '0;
            r_idx   <= '0;
            r_vp    <= VR_V;
            r_spike <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_spike <= 1'b0;
            r_done  <= 1'b0;
            if (w_accept) begin
                r_a    <= a;
                r_w    <= w;
                r_bias <= bias;
                r_leak <= r_vp >>> LEAK_SHIFT;
                r_idx  <= '0;
            end
            if (w_en) r_idx <= r_idx + IW'(1);
            if (w_upd) begin
                r_done <= 1'b1;
                if (w_fire) begin
                    r_spike <= 1'b1;
                    r_vp    <= VR_V;
                end else begin
                    r_vp <= w_vnew;
                end
            end
`ifdef NEURON_REFRACTORY_EN
            if (w_ref) r_done <= 1'b1;
`endif
        end
    end

`ifdef NEURON_REFRACTORY_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_upd && w_fire) begin
            r_cnt <= CW'(REFRAC_CYC);
        end else if (w_ref) begin
            r_cnt <= r_cnt - CW'(1);
        end
    end
`endif

endmodule

// File: tb/tb_neuron_lif_n.sv
// tb_neuron_lif_n: self-checking bench for neuron_lif_n (N_IN=2).
// Two instances: threshold 100 and threshold 32767, sharing data inputs.
module tb_neuron_lif_n;

    localparam int N    = 2;
    localparam int DW   = 8;
    localparam int VW   = 16;
    localparam int RCYC = 2;
`ifdef NEURON_REFRACTORY_EN
    localparam bit REF_EN = 1'b1;
`else
    localparam bit REF_EN = 1'b0;
`endif

    typedef int arr_t[2];

    logic              clk = 1'b0;
    logic              rst;
    logic              v0, v1;
    logic [N*DW-1:0]   a, w;
    logic [DW-1:0]     bias;
    logic              rdy0, rdy1, spk0, spk1, dn0, dn1;
    logic [VW-1:0]     vp0, vp1;

    int checks = 0;
    int errors = 0;
    int m_vp[2];
    int m_ref[2];
    int th[2];

    always #5 clk = ~clk;

    neuron_lif_n #(.N_IN(N), .DW(DW), .VW(VW), .THRESHOLD(100),
                   .V_RESET(0), .LEAK_SHIFT(3), .REFRAC_CYC(RCYC)) u_dut (
        .clk(clk), .rst(rst), .step_valid(v0), .step_ready(rdy0),
        .a(a), .w(w), .bias(bias), .vp(vp0), .spike(spk0), .done(dn0));

    neuron_lif_n #(.N_IN(N), .DW(DW), .VW(VW), .THRESHOLD(32767),
                   .V_RESET(0), .LEAK_SHIFT(3), .REFRAC_CYC(RCYC)) u_sat (
        .clk(clk), .rst(rst), .step_valid(v1), .step_ready(rdy1),
        .a(a), .w(w), .bias(bias), .vp(vp1), .spike(spk1), .done(dn1));

    function automatic int sat16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return int'(x);
    endfunction

    // Reference: one timestep of a LIF neuron in plain integer arithmetic.
    task automatic model_step(input int k, input arr_t av, input arr_t wv,
                              input int b, output int evp, output bit espk,
                              output int elat);
        longint s;
        int     v;
        if (m_ref[k] > 0) begin
            m_ref[k] = m_ref[k] - 1;
            espk = 1'b0;
            evp  = m_vp[k];
            elat = 1;
            return;
        end
        s = longint'(m_vp[k]) + b - (m_vp[k] >>> 3);
        for (int i = 0; i < N; i++) s += longint'(av[i] * wv[i]);
        v    = sat16(s);
        elat = N + 1;
        if (v >= th[k]) begin
            espk    = 1'b1;
            m_vp[k] = 0;
            m_ref[k] = REF_EN ? RCYC : 0;
        end else begin
            espk    = 1'b0;
            m_vp[k] = v;
        end
        evp = m_vp[k];
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v0 = 1'b0;
        v1 = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_vp[k]  = 0;
            m_ref[k] = 0;
        end
    endtask

    // Drives one step on instance k; entered and left at a negedge.
    task automatic run_step(input int k, input arr_t av, input arr_t wv,
                            input int b, output int lat, output int ovp,
                            output bit ospk, output int nspk,
                            output bit after_done);
        int cyc;
        cyc = 0;
        while (!((k == 0) ? rdy0 : rdy1) && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        a    = {DW'(av[1]), DW'(av[0])};
        w    = {DW'(wv[1]), DW'(wv[0])};
        bias = DW'(b);
        if (k == 0) v0 = 1'b1; else v1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        v1 = 1'b0;
        lat  = -1;
        ovp  = 0;
        ospk = 1'b0;
        nspk = 0;
        for (int c = 1; c <= 40; c++) begin
            a    = 16'($urandom);
            w    = 16'($urandom);
            bias = 8'($urandom);
            @(negedge clk);
            if ((k == 0) ? spk0 : spk1) nspk++;
            if ((k == 0) ? dn0 : dn1) begin
                lat  = c;
                ovp  = (k == 0) ? int'($signed(vp0)) : int'($signed(vp1));
                ospk = (k == 0) ? spk0 : spk1;
                break;
            end
        end
        @(negedge clk);
        if ((k == 0) ? spk0 : spk1) nspk++;
        after_done = (k == 0) ? dn0 : dn1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (vp0 !== 16'd0) begin
            errors++; $display("FAIL reset_vp got %0d want 0", vp0);
        end
        checks++;
        if (spk0 !== 1'b0 || spk1 !== 1'b0) begin
            errors++; $display("FAIL reset_spike got %b%b want 00", spk0, spk1);
        end
        checks++;
        if (dn0 !== 1'b0 || dn1 !== 1'b0) begin
            errors++; $display("FAIL reset_done got %b%b want 00", dn0, dn1);
        end
        checks++;
        if (rdy0 !== 1'b1 || rdy1 !== 1'b1) begin
            errors++; $display("FAIL reset_ready got %b%b want 11", rdy0, rdy1);
        end
    endtask

    task automatic test_integrate();
        arr_t av, wv;
        int exp_v[3];
        int lat, ovp, nspk, evp, elat;
        bit ospk, aft, espk;
        exp_v = '{6, 12, 17};
        av = '{1, 1};
        wv = '{3, 2};
        do_reset();
        for (int s = 0; s < 3; s++) begin
            model_step(0, av, wv, 1, evp, espk, elat);
            run_step(0, av, wv, 1, lat, ovp, ospk, nspk, aft);
            checks++;
            if (ovp !== exp_v[s]) begin
                errors++; $display("FAIL integ_vp[%0d] got %0d want %0d", s, ovp, exp_v[s]);
            end
            checks++;
            if (lat !== N + 1) begin
                errors++; $display("FAIL integ_lat[%0d] got %0d want %0d", s, lat, N + 1);
            end
            checks++;
            if (nspk !== 0 || aft !== 1'b0) begin
                errors++; $display("FAIL integ_pulse[%0d] spikes %0d done_after %b want 0 0", s, nspk, aft);
            end
        end
    endtask

    task automatic test_fire();
        arr_t av, wv;
        int lat, ovp, nspk, evp, elat;
        bit ospk, aft, espk;
        av = '{10, 10};
        wv = '{5, 5};
        do_reset();
        for (int s = 0; s < 4; s++) begin
            model_step(0, av, wv, 0, evp, espk, elat);
            run_step(0, av, wv, 0, lat, ovp, ospk, nspk, aft);
            checks++;
            if (ospk !== espk || nspk !== int'(espk)) begin
                errors++; $display("FAIL fire_spike[%0d] got %b (%0d cycles) want %b", s, ospk, nspk, espk);
            end
            checks++;
            if (ovp !== evp) begin
                errors++; $display("FAIL fire_vp[%0d] got %0d want %0d", s, ovp, evp);
            end
            checks++;
            if (lat !== elat || aft !== 1'b0) begin
                errors++; $display("FAIL fire_lat[%0d] got %0d done_after %b want %0d", s, lat, aft, elat);
            end
        end
    endtask

    task automatic test_saturation();
        arr_t av, wn, wp;
        int lat, ovp, nspk, evp, elat;
        bit ospk, aft, espk;
        int exp_neg[2];
        exp_neg = '{-32640, -32768};
        av = '{127, 127};
        wn = '{-128, -128};
        wp = '{127, 127};
        do_reset();
        for (int s = 0; s < 2; s++) begin
            model_step(0, av, wn, -128, evp, espk, elat);
            run_step(0, av, wn, -128, lat, ovp, ospk, nspk, aft);
            checks++;
            if (ovp !== exp_neg[s] || nspk !== 0) begin
                errors++; $display("FAIL sat_neg[%0d] got %0d spikes %0d want %0d 0", s, ovp, nspk, exp_neg[s]);
            end
        end
        for (int s = 0; s < 2; s++) begin
            model_step(1, av, wp, 127, evp, espk, elat);
            run_step(1, av, wp, 127, lat, ovp, ospk, nspk, aft);
            checks++;
            if (ovp !== evp || ospk !== espk || nspk !== int'(espk)) begin
                errors++; $display("FAIL sat_pos[%0d] got vp %0d spike %b want vp %0d spike %b", s, ovp, ospk, evp, espk);
            end
        end
    endtask

    task automatic test_random();
        arr_t av, wv;
        int k, b, lat, ovp, nspk, evp, elat;
        bit ospk, aft, espk;
        do_reset();
        for (int it = 0; it < 40; it++) begin
            k = int'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    av[i] = int'($urandom_range(0, 255)) - 128;
                    wv[i] = int'($urandom_range(0, 255)) - 128;
                end else begin
                    av[i] = int'($urandom_range(0, 20)) - 10;
                    wv[i] = int'($urandom_range(0, 20)) - 10;
                end
            end
            b = int'($urandom_range(0, 255)) - 128;
            model_step(k, av, wv, b, evp, espk, elat);
            run_step(k, av, wv, b, lat, ovp, ospk, nspk, aft);
            checks++;
            if (ovp !== evp || ospk !== espk || lat !== elat ||
                nspk !== int'(espk) || aft !== 1'b0) begin
                errors++;
                $display("FAIL rand[%0d] dut%0d got vp %0d sp %b lat %0d want vp %0d sp %b lat %0d",
                         it, k, ovp, ospk, lat, evp, espk, elat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int acc_at[$];
        int dones;
        do_reset();
        a    = '0;
        w    = '0;
        bias = '0;
        v0   = 1'b1;
        dones = 0;
        for (int c = 0; c < 40; c++) begin
            if (rdy0) acc_at.push_back(c);
            if (dn0) dones++;
            @(negedge clk);
        end
        v0 = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (dn0) dones++;
            @(negedge clk);
        end
        checks++;
        if (acc_at.size() !== 40 / (N + 2)) begin
            errors++; $display("FAIL b2b_count got %0d want %0d", acc_at.size(), 40 / (N + 2));
        end
        for (int i = 1; i < acc_at.size(); i++) begin
            checks++;
            if (acc_at[i] - acc_at[i-1] !== N + 2) begin
                errors++; $display("FAIL b2b_gap[%0d] got %0d want %0d", i, acc_at[i] - acc_at[i-1], N + 2);
            end
        end
        checks++;
        if (dones !== acc_at.size() || vp0 !== 16'd0) begin
            errors++; $display("FAIL b2b_done got %0d vp %0d want %0d vp 0", dones, vp0, acc_at.size());
        end
    endtask

    task automatic test_reset_mid();
        arr_t av, wv;
        int lat, ovp, nspk, evp, elat, dones;
        bit ospk, aft, espk;
        av = '{1, 1};
        wv = '{3, 2};
        do_reset();
        model_step(0, av, wv, 1, evp, espk, elat);
        run_step(0, av, wv, 1, lat, ovp, ospk, nspk, aft);
        checks++;
        if (ovp !== 6) begin
            errors++; $display("FAIL midrst_pre got %0d want 6", ovp);
        end
        v0 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        v0 = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_vp[0] = 0;
        m_ref[0] = 0;
        checks++;
        if (rdy0 !== 1'b1 || vp0 !== 16'd0 || dn0 !== 1'b0) begin
            errors++; $display("FAIL midrst_state got rdy %b vp %0d done %b want 1 0 0", rdy0, vp0, dn0);
        end
        dones = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (dn0) dones++;
        end
        checks++;
        if (dones !== 0) begin
            errors++; $display("FAIL midrst_nodone got %0d want 0", dones);
        end
    endtask

    initial begin
        rst  = 1'b1;
        v0   = 1'b0;
        v1   = 1'b0;
        a    = '0;
        w    = '0;
        bias = '0;
        th[0] = 100;
        th[1] = 32767;
        @(negedge clk);
        test_reset();
        test_integrate();
        test_fire();
        test_saturation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_lif_n.md
# neuron_lif_n

Parametrised leaky integrate-and-fire neuron with N_IN synaptic inputs. It is the next-generation replacement for our fixed two-input `neuron`. On each accepted timestep it time-multiplexes one signed multiply-accumulate per cycle into the membrane potential, then applies bias and leak, fires on threshold and resets. It sits between the spike/activation fabric and the layer controller, which drives timesteps through a valid/ready handshake.

## Interface
Parameters:
- N_IN, 4: number of synaptic inputs (≥1)
- DW, 8: signed width of activations, weights and bias
- VW, 16: signed width of membrane potential
- THRESHOLD, 100: signed firing threshold, compared with ≥
- V_RESET, 0: membrane value after reset and after a spike
- LEAK_SHIFT, 3: leak term is vp >>> LEAK_SHIFT (arithmetic shift)
- REFRAC_CYC, 2: refractory length in timesteps (used only with the macro)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- step_valid  in  1  timestep request
- step_ready  out  1  block idle and able to accept a timestep
- a  in  N_IN*DW  activations, signed; lane i at [i*DW +: DW]
- w  in  N_IN*DW  weights, signed; same packing as a
- bias  in  DW  signed bias
- vp  out  VW  membrane potential (registered)
- spike  out  1  one-cycle fire pulse
- done  out  1  one-cycle timestep-complete pulse

## Operation
- Clocking: one clock, clk. Reset rst is synchronous and active-high.
- Reset: state=IDLE, vp=V_RESET, spike=0, done=0, step_ready=1, refractory counter=0. rst overrides everything, including mid-step. An in-flight step is discarded and produces no done.
- States: IDLE, ACCUM, UPDATE, and REFRAC (REFRAC exists only with the macro).
- IDLE:
  - step_ready=1.
  - step_valid&&step_ready accepts the step: latch a, w and bias; acc←sign-extended vp; leak←vp>>>LEAK_SHIFT; idx←0.
  - Go to ACCUM, or to REFRAC if the refractory counter is nonzero.
  - a, w and bias are sampled only at acceptance.
- ACCUM:
  - Each cycle, acc += a[idx]*w[idx] (full 2*DW-bit signed product), then idx++.
  - After N_IN cycles, go to UPDATE.
  - acc width is VW+2*DW+$clog2(N_IN)+1, so it cannot overflow.
- UPDATE (one cycle):
  - v_new = sat_VW(acc + bias − leak), clamped to [−2^(VW−1), 2^(VW−1)−1].
  - If v_new ≥ THRESHOLD: spike=1, vp←V_RESET, and load the refractory counter with REFRAC_CYC.
  - Otherwise: vp←v_new.
  - In both cases done=1 and the next state is IDLE.
- REFRAC:
  - The accepted step is consumed without integration: vp is held, spike=0, done=1, the counter decrements, and the next state is IDLE.
- step_valid while step_ready=0 is ignored; no queueing.
- spike and done are never high for more than one cycle.

## Timing
- Accept on edge E0.
- Normal step: ACCUM occupies edges E1..E_N_IN and UPDATE is edge E_N_IN+1. vp, spike and done are visible in the cycle after E_N_IN+1, which is also when step_ready returns to 1.
- Maximum throughput: one step per N_IN+2 edges, with step_valid held high.
- A step accepted in the same cycle that done=1 is legal.
- Refractory step: done is visible in the cycle after E1.

## Configuration
- NEURON_REFRACTORY_EN defined: the REFRAC state and counter are compiled in. After a spike, the next REFRAC_CYC accepted steps are consumed as described under REFRAC.
- NEURON_REFRACTORY_EN undefined: there is no counter or REFRAC state, REFRAC_CYC is ignored, and every accepted step integrates.

## Structure
- Package neuron_pkg holds:
  - the state enum typedef;
  - the sat_VW saturation function;
  - the default parameter constants;
  - the lane packing helper.
- Sub-module neuron_mac is the single signed multiply-accumulate lane (product plus accumulator register, with clear/load/enable controls). neuron_lif_n owns the FSM, leak, threshold and refractory logic.

## Test plan
- Reset: assert rst for 2 cycles → vp=0, spike=0, done=0, step_ready=1. Assert rst mid-ACCUM → next cycle step_ready=1, vp=V_RESET, no done.
- Integration and leak: N_IN=2, a={1,1}, w={3,2}, bias=1, LEAK_SHIFT=3, three steps → vp=6, 12, 17; done N_IN+1 edges after each accept; spike=0 throughout.
- Fire: a={10,10}, w={5,5}, bias=0, THRESHOLD=100, vp=0 → spike=1 for one cycle, vp=0 afterwards.
- Refractory: macro defined, REFRAC_CYC=2, repeat the fire stimulus → next 2 steps give done with latency 1, vp=0, spike=0; the 3rd step spikes again. Macro undefined → every step spikes.
- Saturation: a={127,127}, w={−128,−128}, bias=−128 → step 1 vp=−32640, step 2 vp=−32768 (clamped), no spike. With w={127,127}, bias=127, THRESHOLD=32767 → step 2 saturates to 32767 and spikes.
- Handshake: step_valid held high → accepts spaced N_IN+2 edges apart. Inputs changed during ACCUM → no effect on the result.
